// File: rtl/regfile_port_sched_if.sv
// Bundle between the register-file port scheduler, its three requesters and the
// synchronous-read register file array.
interface regfile_port_sched_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [ADDR_W-1:0] rd_dest;
  logic              rd_dest_en;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_stall;

  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_gnt;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_gnt;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;

  logic [NREG-1:0]   busy_vec;

  modport slave (
    input  rd_req, rd_addr1, rd_addr2, rd_dest, rd_dest_en,
    output rd_gnt, rd_valid, rd_data1, rd_data2, rd_stall,
    input  wb_req, wb_addr, wb_data,
    output wb_gnt,
    input  dbg_req, dbg_addr, dbg_data,
    output dbg_gnt,
    output rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    output busy_vec
  );

  modport master (
    output rd_req, rd_addr1, rd_addr2, rd_dest, rd_dest_en,
    input  rd_gnt, rd_valid, rd_data1, rd_data2, rd_stall,
    output wb_req, wb_addr, wb_data,
    input  wb_gnt,
    output dbg_req, dbg_addr, dbg_data,
    input  dbg_gnt,
    input  rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    input  busy_vec
  );
endinterface

// File: rtl/regfile_port_sched.sv
// Single-slot register-file port scheduler: WB > DBG > RD priority with a
// starvation override for reads, plus a busy-bit scoreboard against RAW hazards.
module regfile_port_sched #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_port_sched_if.slave  bus
);
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {ARB, RDRET} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  starve_reg;
  logic              zero1_reg;
  logic              zero2_reg;
  logic [NREG-1:0]   busy_vec;

  logic rd_hz;
  logic rd_ok;
  logic rd_starved;
  logic dbg_ok;
  logic wb_gnt;
  logic dbg_gnt;
  logic rd_gnt;

  assign rd_hz      = busy_vec[bus.rd_addr1] | busy_vec[bus.rd_addr2]
                    | (bus.rd_dest_en & busy_vec[bus.rd_dest]);
  assign rd_ok      = bus.rd_req & ~rd_hz;
  assign rd_starved = rd_ok & (starve_reg == CNT_W'(STARVE_MAX));
  assign dbg_ok     = bus.dbg_req & ~busy_vec[bus.dbg_addr];

  // Grants are gated by rst_n so they drop the instant reset asserts.
  assign wb_gnt  = rst_n & bus.wb_req & ~rd_starved;
  assign dbg_gnt = rst_n & dbg_ok & ~bus.wb_req & ~rd_starved;
  assign rd_gnt  = rst_n & rd_ok & (rd_starved | (~bus.wb_req & ~dbg_ok));

  assign bus.wb_gnt   = wb_gnt;
  assign bus.dbg_gnt  = dbg_gnt;
  assign bus.rd_gnt   = rd_gnt;
  assign bus.rd_stall = bus.rd_req & rd_hz;

  assign bus.rf_we     = (wb_gnt & (|bus.wb_addr)) | (dbg_gnt & (|bus.dbg_addr));
  assign bus.rf_waddr  = dbg_gnt ? bus.dbg_addr : bus.wb_addr;
  assign bus.rf_wdata  = dbg_gnt ? bus.dbg_data : bus.wb_data;
  assign bus.rf_raddr1 = bus.rd_addr1;
  assign bus.rf_raddr2 = bus.rd_addr2;

  // The array's own output register supplies the operand in the RDRET cycle.
  assign bus.rd_valid = (state_reg == RDRET);
  assign bus.rd_data1 = (state_reg == RDRET && !zero1_reg) ? bus.rf_rdata1 : '0;
  assign bus.rd_data2 = (state_reg == RDRET && !zero2_reg) ? bus.rf_rdata2 : '0;
  assign bus.busy_vec = busy_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ARB;
      starve_reg <= '0;
      zero1_reg  <= 1'b0;
      zero2_reg  <= 1'b0;
    end else begin
      state_reg <= rd_gnt ? RDRET : ARB;
      if (rd_gnt) begin
        zero1_reg <= (bus.rd_addr1 == '0);
        zero2_reg <= (bus.rd_addr2 == '0);
      end
      if (rd_gnt || !bus.rd_req) begin
        starve_reg <= '0;
      end else if ((wb_gnt | dbg_gnt) && rd_ok && starve_reg != CNT_W'(STARVE_MAX)) begin
        starve_reg <= starve_reg + 1'b1;
      end
    end
  end

  assign busy_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      logic bit_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bit_reg <= 1'b0;
        end else if (rd_gnt && bus.rd_dest_en && bus.rd_dest == ADDR_W'(gi)) begin
          bit_reg <= 1'b1;
        end else if (wb_gnt && bus.wb_addr == ADDR_W'(gi)) begin
          bit_reg <= 1'b0;
        end
      end
      assign busy_vec[gi] = bit_reg;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched: behavioural scoreboard model checked on
// every negedge, plus literal expectations at key points of each scenario.
module tb_regfile_port_sched;
  localparam int STARVE = 2;
  localparam int W_NONE = 0, W_WB = 1, W_DBG = 2, W_RD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_port_sched_if bus ();

  regfile_port_sched #(.ADDR_W(5), .DATA_W(32), .NREG(32), .STARVE_MAX(STARVE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Register-file array: synchronous read, not reset, register 0 storage not hardwired.
  logic [31:0] tb_rf [32];
  bit          rf_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) tb_rf[i] <= 32'h1000_0000 + i;
      rf_loaded <= 1'b1;
    end else if (bus.rf_we) begin
      tb_rf[bus.rf_waddr] <= bus.rf_wdata;
    end
    bus.rf_rdata1 <= tb_rf[bus.rf_raddr1];
    bus.rf_rdata2 <= tb_rf[bus.rf_raddr2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register contents, reserved set, pending read.
  logic [31:0] mem_m [32];
  logic [31:0] busy_m;
  int          cnt_m;
  bit          pend_v;
  logic [31:0] pend_d1, pend_d2;
  bit          model_loaded = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (!model_loaded) begin
        for (int i = 0; i < 32; i++) mem_m[i] = 32'h1000_0000 + i;
        model_loaded = 1'b1;
      end
      busy_m = '0;
      cnt_m  = 0;
      pend_v = 1'b0;
    end else begin
      int  win;
      bit  hz, rd_ok, exp_we;
      int  a1, a2, d, wa;
      logic [31:0] wd;
      a1 = int'(bus.rd_addr1);
      a2 = int'(bus.rd_addr2);
      d  = int'(bus.rd_dest);
      hz = busy_m[a1] | busy_m[a2] | (bus.rd_dest_en & busy_m[d]);
      rd_ok = bus.rd_req && !hz;
      if (rd_ok && cnt_m == STARVE)                      win = W_RD;
      else if (bus.wb_req)                               win = W_WB;
      else if (bus.dbg_req && !busy_m[int'(bus.dbg_addr)]) win = W_DBG;
      else if (rd_ok)                                    win = W_RD;
      else                                               win = W_NONE;

      wa = (win == W_DBG) ? int'(bus.dbg_addr) : int'(bus.wb_addr);
      wd = (win == W_DBG) ? bus.dbg_data : bus.wb_data;
      exp_we = (win == W_WB || win == W_DBG) && wa != 0;

      chk("m_wb_gnt",   32'(bus.wb_gnt),   32'(win == W_WB));
      chk("m_dbg_gnt",  32'(bus.dbg_gnt),  32'(win == W_DBG));
      chk("m_rd_gnt",   32'(bus.rd_gnt),   32'(win == W_RD));
      chk("m_rd_stall", 32'(bus.rd_stall), 32'(bus.rd_req && hz));
      chk("m_rf_we",    32'(bus.rf_we),    32'(exp_we));
      if (exp_we) begin
        chk("m_rf_waddr", 32'(bus.rf_waddr), 32'(wa));
        chk("m_rf_wdata", bus.rf_wdata, wd);
      end
      if (win == W_RD) begin
        chk("m_rf_raddr1", 32'(bus.rf_raddr1), 32'(a1));
        chk("m_rf_raddr2", 32'(bus.rf_raddr2), 32'(a2));
      end
      chk("m_busy_vec", bus.busy_vec, busy_m);
      chk("m_rd_valid", 32'(bus.rd_valid), 32'(pend_v));
      if (pend_v) begin
        chk("m_rd_data1", bus.rd_data1, pend_d1);
        chk("m_rd_data2", bus.rd_data2, pend_d2);
      end

      pend_v = (win == W_RD);
      if (win == W_RD) begin
        pend_d1 = (a1 == 0) ? 32'h0 : mem_m[a1];
        pend_d2 = (a2 == 0) ? 32'h0 : mem_m[a2];
        if (bus.rd_dest_en && d != 0) busy_m[d] = 1'b1;
      end
      if (exp_we) mem_m[wa] = wd;
      if (win == W_WB) busy_m[wa] = 1'b0;
      if (win == W_RD || !bus.rd_req) cnt_m = 0;
      else if (rd_ok && (win == W_WB || win == W_DBG) && cnt_m < STARVE) cnt_m++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] d, input logic en);
    bus.rd_req = 1'b1; bus.rd_addr1 = a1; bus.rd_addr2 = a2;
    bus.rd_dest = d;   bus.rd_dest_en = en;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rd_req = 1'b1; bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd2;
    bus.rd_dest = 5'd0; bus.rd_dest_en = 1'b0;
    bus.wb_req = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h0;
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd4; bus.dbg_data = 32'h0;
    #2;
    chk("rst_wb_gnt",   32'(bus.wb_gnt),   32'h0);
    chk("rst_dbg_gnt",  32'(bus.dbg_gnt),  32'h0);
    chk("rst_rd_gnt",   32'(bus.rd_gnt),   32'h0);
    chk("rst_rf_we",    32'(bus.rf_we),    32'h0);
    chk("rst_busy",     bus.busy_vec,      32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_rd_data1", bus.rd_data1,      32'h0);
    tick(); tick();
    bus.rd_req = 1'b0; bus.wb_req = 1'b0; bus.dbg_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: writeback alone, then read it back
    bus.wb_req = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1;
    chk("t1_wb_gnt",   32'(bus.wb_gnt),   32'h1);
    chk("t1_rf_we",    32'(bus.rf_we),    32'h1);
    chk("t1_rf_waddr", 32'(bus.rf_waddr), 32'h5);
    chk("t1_rf_wdata", bus.rf_wdata,      32'hDEADBEEF);
    tick();
    bus.wb_req = 1'b0;
    set_rd(5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    chk("t1_rd_gnt", 32'(bus.rd_gnt), 32'h1);
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("t1_rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("t1_rd_data1", bus.rd_data1, 32'hDEADBEEF);
    chk("t1_rd_data2", bus.rd_data2, 32'h0);
    tick();

    // 2: RAW hazard on register 7
    set_rd(5'd1, 5'd2, 5'd7, 1'b1);
    #1;
    chk("t2_reserve_gnt", 32'(bus.rd_gnt), 32'h1);
    tick();
    set_rd(5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    chk("t2_busy", bus.busy_vec, 32'h0000_0080);
    chk("t2_stall", 32'(bus.rd_stall), 32'h1);
    chk("t2_no_gnt", 32'(bus.rd_gnt), 32'h0);
    tick();
    bus.wb_req = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_0077;
    #1;
    chk("t2_wb_gnt", 32'(bus.wb_gnt), 32'h1);
    chk("t2_rd_held", 32'(bus.rd_gnt), 32'h0);
    tick();
    bus.wb_req = 1'b0;
    #1;
    chk("t2_rd_gnt", 32'(bus.rd_gnt), 32'h1);
    chk("t2_stall_clear", 32'(bus.rd_stall), 32'h0);
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("t2_rd_data1", bus.rd_data1, 32'h0000_0077);
    tick();

    // 3: WB, DBG and RD together
    bus.wb_req = 1'b1;  bus.wb_addr = 5'd3;  bus.wb_data = 32'h33;
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd4; bus.dbg_data = 32'h44;
    set_rd(5'd3, 5'd4, 5'd0, 1'b0);
    #1;
    chk("t3_c0_wb", 32'(bus.wb_gnt), 32'h1);
    chk("t3_c0_dbg", 32'(bus.dbg_gnt), 32'h0);
    tick();
    bus.wb_req = 1'b0;
    #1;
    chk("t3_c1_dbg", 32'(bus.dbg_gnt), 32'h1);
    chk("t3_c1_rd", 32'(bus.rd_gnt), 32'h0);
    tick();
    bus.dbg_req = 1'b0;
    #1;
    chk("t3_c2_rd", 32'(bus.rd_gnt), 32'h1);
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("t3_rd_data1", bus.rd_data1, 32'h33);
    chk("t3_rd_data2", bus.rd_data2, 32'h44);
    tick();

    // 4: starvation override with writeback held
    bus.wb_req = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    set_rd(5'd10, 5'd11, 5'd0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t4_wb_first", 32'(bus.wb_gnt), 32'h1);
      tick();
    end
    #1;
    chk("t4_rd_gnt", 32'(bus.rd_gnt), 32'h1);
    chk("t4_wb_wait", 32'(bus.wb_gnt), 32'h0);
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("t4_wb_resume", 32'(bus.wb_gnt), 32'h1);
    tick();
    bus.wb_req = 1'b0;
    tick();

    // DBG blocked on a reserved target until writeback clears it
    set_rd(5'd1, 5'd2, 5'd12, 1'b1);
    tick();
    bus.rd_req = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd12; bus.dbg_data = 32'h0000_C0DE;
    #1;
    chk("dbg_blocked0", 32'(bus.dbg_gnt), 32'h0);
    tick();
    #1;
    chk("dbg_blocked1", 32'(bus.dbg_gnt), 32'h0);
    bus.wb_req = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h1212;
    tick();
    bus.wb_req = 1'b0;
    #1;
    chk("dbg_unblocked", 32'(bus.dbg_gnt), 32'h1);
    chk("dbg_wdata", bus.rf_wdata, 32'h0000_C0DE);
    tick();
    bus.dbg_req = 1'b0;

    // 5: register 0
    bus.wb_req = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    #1;
    chk("t5_wb_gnt", 32'(bus.wb_gnt), 32'h1);
    chk("t5_rf_we", 32'(bus.rf_we), 32'h0);
    tick();
    bus.wb_req = 1'b0;
    set_rd(5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("t5_busy", bus.busy_vec, 32'h0);
    chk("t5_rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("t5_rd_data1", bus.rd_data1, 32'h0);
    chk("t5_rd_data2", bus.rd_data2, 32'h0);
    tick();

    // 6: asynchronous reset with a read pending and register 7 reserved
    set_rd(5'd1, 5'd2, 5'd7, 1'b1);
    tick();
    bus.rd_req = 1'b0;
    bus.wb_req = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h5555;
    #1;
    chk("t6_pre_busy", bus.busy_vec, 32'h0000_0080);
    chk("t6_pre_valid", 32'(bus.rd_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", bus.busy_vec, 32'h0);
    chk("t6_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("t6_wb_gnt", 32'(bus.wb_gnt), 32'h0);
    chk("t6_rf_we", 32'(bus.rf_we), 32'h0);
    tick();
    bus.wb_req = 1'b0;
    rst_n = 1'b1;
    tick();
    set_rd(5'd9, 5'd3, 5'd0, 1'b0);
    tick();
    bus.rd_req = 1'b0;
    #1;
    chk("t6_after_data1", bus.rd_data1, 32'h99);
    chk("t6_after_data2", bus.rd_data2, 32'h33);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_port_sched.md
Name: regfile_port_sched

Overview:
- Scheduler in front of the 32x32 general-purpose register file, which has one shared access slot per cycle.
- Each cycle it grants one of three requesters: writeback (WB), debug/program loader (DBG), or decode operand read (RD).
- Keeps a busy-bit scoreboard so decode never reads a register with a write still pending.
- Drives the register file's read/write address and enable pins directly and returns registered operand data to decode.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREG, 32, number of architectural registers; register 0 is hard zero.
- STARVE_MAX, 2, consecutive write grants allowed while RD waits un-hazarded.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  1  decode requests an operand read.
- rd_addr1, rd_addr2  in  ADDR_W  source registers.
- rd_dest  in  ADDR_W  destination register to reserve.
- rd_dest_en  in  1  reserve rd_dest on grant.
- rd_gnt  out  1  read granted this cycle (combinational).
- rd_valid  out  1  registered pulse, one cycle after rd_gnt.
- rd_data1, rd_data2  out  DATA_W  operands, valid when rd_valid is high.
- rd_stall  out  1  rd_req blocked by a hazard (combinational).
- wb_req  in  1  writeback request.
- wb_addr  in  ADDR_W  writeback target.
- wb_data  in  DATA_W  writeback data.
- wb_gnt  out  1  writeback granted.
- dbg_req  in  1  debug/loader write request.
- dbg_addr  in  ADDR_W  debug target.
- dbg_data  in  DATA_W  debug data.
- dbg_gnt  out  1  debug write granted.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- rf_raddr1, rf_raddr2  out  ADDR_W  register file read addresses; the register file reads synchronously, so data appears next cycle.
- rf_rdata1, rf_rdata2  in  DATA_W  register file read data.
- busy_vec  out  NREG  scoreboard contents, for debug visibility.

Behaviour:
- Reset (async, rst_n=0):
  - busy_vec=0, rd_valid=0, rd_data1/2=0, starvation counter=0, state=ARB.
  - All grants and rf_we are 0 while rst_n=0.
- Hazard:
  - rd_hz = busy[rd_addr1] | busy[rd_addr2] | (rd_dest_en & busy[rd_dest]).
  - busy[0] is constant 0.
  - rd_stall = rd_req & rd_hz.
- Arbitration, at most one grant per cycle:
  - Priority is WB > DBG > RD.
  - Exception: when the starvation counter equals STARVE_MAX, and rd_req is high, and rd_hz is 0, RD wins.
  - DBG is eligible only when busy[dbg_addr]=0; otherwise dbg_gnt stays low until that bit clears.
- Starvation counter:
  - Increments (saturating) on a WB or DBG grant while rd_req & !rd_hz.
  - Clears on rd_gnt or when rd_req=0.
- Register file drive on a write grant:
  - rf_we=1, with rf_waddr/rf_wdata taken from the winning requester.
  - rf_we is forced to 0 when the target address is 0; the grant still asserts.
- Register file drive on rd_gnt:
  - rf_raddr1=rd_addr1, rf_raddr2=rd_addr2.
  - Next cycle: rd_valid=1 and rd_data1/2 capture rf_rdata1/2.
  - Address 0 returns 0, forced by this block.
- Scoreboard:
  - rd_gnt with rd_dest_en and rd_dest≠0 sets busy[rd_dest].
  - wb_gnt clears busy[wb_addr].
  - Set and clear never coincide because only one grant is issued per cycle.
- Error handling:
  - wb_gnt to a non-busy register is legal: the write happens and busy is unchanged.
  - dbg writes never touch the scoreboard.
- State machine:
  - ARB: normal arbitration.
  - RDRET: one cycle after rd_gnt; capture data and raise rd_valid. Arbitration continues in this state (fully pipelined), so back-to-back reads give rd_valid on consecutive cycles.
  - Return to ARB when there is no new rd_gnt.
- Reset mid-operation: a pending rd_valid is dropped and the scoreboard is cleared; requesters must re-issue.
- Requesters hold req and payload stable until their grant.

Test Plan:
1. Reset then WB-only:
   - Stimulus: after reset, wb_req with wb_addr=5, wb_data=0xDEADBEEF.
   - Response: wb_gnt=1 in the same cycle; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
   - Follow-up read of register 5: rd_valid one cycle after rd_gnt, rd_data1=0xDEADBEEF.
2. RAW hazard:
   - Stimulus: read with rd_dest=7, rd_dest_en=1 is granted (busy[7]=1); then rd_addr1=7.
   - Response: rd_stall=1 and no rd_gnt until wb_gnt for register 7 fires; rd_gnt follows on the next cycle.
3. Simultaneous WB+DBG+RD, all un-hazarded:
   - Response: wb_gnt on cycle 0, dbg_gnt on cycle 1, rd_gnt on cycle 2.
4. Starvation:
   - Stimulus: wb_req held continuously, rd_req un-hazarded, STARVE_MAX=2.
   - Response: rd_gnt on the 3rd cycle, then wb_gnt resumes.
5. Register 0:
   - Stimulus: wb_addr=0 with data 0xFFFFFFFF.
   - Response: wb_gnt=1 with rf_we=0.
   - Read of register 0 returns 0; rd_dest=0 leaves busy_vec=0.
6. Async reset mid-operation:
   - Stimulus: rst_n falls while busy_vec=0x00000080 and rd_valid is pending.
   - Response: busy_vec=0, rd_valid=0 and all grants low immediately, without waiting for a clock edge.
